axis_pkt_gen: RTL and testbench

//  Parametrised AXI4-Stream packet generator; the synthesizable successor of the file-driven KVS bench stimulus.

---
 rtl/axis_pkt_gen_pkg.sv | 20 ++
 rtl/axis_pkt_gen_mem.sv | 33 +++
 rtl/axis_pkt_gen.sv | 221 ++++++++++++++++++++++
 tb/tb_axis_pkt_gen.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkt_gen_pkg.sv
// Package for the AXI4-Stream packet generator.
// Contents:
//   state_e  replay state machine encoding
//   STAT_W   width of the statistics counters
//   sat_inc  saturating increment for the statistics counters
package axis_pkt_gen_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StGap
  } state_e;

  localparam int unsigned STAT_W = 32;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/axis_pkt_gen_mem.sv
// Beat memory for the packet generator: DEPTH x WIDTH flop array, synchronous write,
// asynchronous read. Contents are not reset.
// Ports:
//   clk    write clock
//   we     write enable
//   waddr  write index
//   wdata  write word
//   raddr  read index
//   rdata  read word (combinational)
module axis_pkt_gen_mem #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 73,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_pkt_gen.sv
// AXI4-Stream packet generator. Replays a programmed beat sequence on an AXI-S master with
// optional inter-packet gap, repeat count, stop-at-packet-boundary and a per-packet sequence
// number on tuser.
// Optional feature macro: AXIS_PKT_GEN_STATS_EN enables the saturating stat_* counters;
// without it the stat_* ports are tied to zero.
// Ports:
//   clk_390, clk_390_rst_n             clock, asynchronous active-low reset
//   cfg_we/addr/tdata/tkeep/tlast      beat memory write (dropped while busy)
//   num_beats, gap_cycles, repeat_cnt  run parameters, sampled on an accepted start
//   start, stop                        run control pulses
//   m_axis_*                           AXI-S master
//   busy, done                         run status; done is a one-cycle pulse on return to idle
//   stat_pkts/stat_beats/stat_stalls   handshaked packets, handshaked beats, stalled cycles
module axis_pkt_gen
  import axis_pkt_gen_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned USER_W = 64,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned GAP_W  = 16,
  parameter int unsigned RPT_W  = 16,
  parameter int unsigned KEEP_W = DATA_W / 8,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk_390,
  input  logic              clk_390_rst_n,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [DATA_W-1:0] cfg_tdata,
  input  logic [KEEP_W-1:0] cfg_tkeep,
  input  logic              cfg_tlast,
  input  logic [AW:0]       num_beats,
  input  logic [GAP_W-1:0]  gap_cycles,
  input  logic [RPT_W-1:0]  repeat_cnt,
  input  logic              start,
  input  logic              stop,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic [USER_W-1:0] m_axis_tuser,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              busy,
  output logic              done,
  output logic [STAT_W-1:0] stat_pkts,
  output logic [STAT_W-1:0] stat_beats,
  output logic [STAT_W-1:0] stat_stalls
);

  localparam int unsigned MEM_W = DATA_W + KEEP_W + 1;
  localparam logic [AW:0] MAX_BEATS = (AW+1)'(DEPTH);

  state_e            state;
  logic [AW-1:0]     idx;
  logic [RPT_W-1:0]  pass;
  logic [USER_W-1:0] seq;
  logic [AW:0]       nb_q;
  logic [GAP_W-1:0]  gap_q;
  logic [GAP_W-1:0]  gap_cnt;
  logic [RPT_W-1:0]  rpt_q;
  logic              stop_pend;
  logic              final_q;   // beat in the output register closes the last pass

  logic [MEM_W-1:0]  rd_word;
  logic              start_ok;
  logic              hs;
  logic              hs_last;
  logic              stop_eff;
  logic              end_run;
  logic              load_beat;
  logic              idx_last;
  logic [USER_W-1:0] seq_nxt;

  axis_pkt_gen_mem #(
    .DEPTH (DEPTH),
    .WIDTH (MEM_W),
    .AW    (AW)
  ) u_mem (
    .clk   (clk_390),
    .we    (cfg_we & ~busy),
    .waddr (cfg_addr),
    .wdata ({cfg_tdata, cfg_tkeep, cfg_tlast}),
    .raddr (idx),
    .rdata (rd_word)
  );

  assign start_ok = (state == StIdle) && start && (num_beats != '0) && (num_beats <= MAX_BEATS);
  assign hs       = m_axis_tvalid & m_axis_tready;
  assign hs_last  = hs & m_axis_tlast;
  // A stop arriving in the same cycle as a tlast handshake still ends the run there.
  assign stop_eff = stop_pend | stop;
  assign end_run  = hs_last & (final_q | stop_eff);
  assign seq_nxt  = hs_last ? seq + 1'b1 : seq;
  assign idx_last = ({1'b0, idx} == nb_q - 1'b1);

  // Output register reload: in RUN whenever the slot is free unless the run ends or a gap
  // starts on this handshake; in GAP on the cycle the counter reaches the programmed gap.
  always_comb begin
    load_beat = 1'b0;
    unique case (state)
      StRun:   load_beat = (!m_axis_tvalid || m_axis_tready) &&
                           !(hs_last && (end_run || gap_q != '0));
      StGap:   load_beat = !stop_eff && (gap_cnt == gap_q);
      default: load_beat = 1'b0;
    endcase
  end

  always_ff @(posedge clk_390 or negedge clk_390_rst_n) begin
    if (!clk_390_rst_n) begin
      state         <= StIdle;
      idx           <= '0;
      pass          <= '0;
      seq           <= '0;
      nb_q          <= '0;
      gap_q         <= '0;
      gap_cnt       <= '0;
      rpt_q         <= '0;
      stop_pend     <= 1'b0;
      final_q       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else begin
      done <= 1'b0;
      seq  <= seq_nxt;
      if (stop && state != StIdle) begin
        stop_pend <= 1'b1;
      end

      if (load_beat) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= rd_word[MEM_W-1 -: DATA_W];
        m_axis_tkeep  <= rd_word[KEEP_W:1];
        m_axis_tlast  <= rd_word[0] | idx_last;
        m_axis_tuser  <= seq_nxt;
        final_q       <= idx_last && (rpt_q != '0) && (pass + 1'b1 == rpt_q);
        if (idx_last) begin
          idx  <= '0;
          pass <= pass + 1'b1;
        end else begin
          idx <= idx + 1'b1;
        end
      end else if (hs) begin
        m_axis_tvalid <= 1'b0;
      end

      unique case (state)
        StIdle: begin
          if (start_ok) begin
            state     <= StRun;
            busy      <= 1'b1;
            nb_q      <= num_beats;
            gap_q     <= gap_cycles;
            rpt_q     <= repeat_cnt;
            idx       <= '0;
            pass      <= '0;
            seq       <= '0;
            stop_pend <= stop;
          end
        end
        StRun: begin
          if (end_run) begin
            state     <= StIdle;
            busy      <= 1'b0;
            done      <= 1'b1;
            stop_pend <= 1'b0;
          end else if (hs_last && gap_q != '0) begin
            state   <= StGap;
            gap_cnt <= GAP_W'(1);
          end
        end
        StGap: begin
          if (stop_eff) begin
            state     <= StIdle;
            busy      <= 1'b0;
            done      <= 1'b1;
            stop_pend <= 1'b0;
          end else if (gap_cnt == gap_q) begin
            state <= StRun;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

`ifdef AXIS_PKT_GEN_STATS_EN
  always_ff @(posedge clk_390 or negedge clk_390_rst_n) begin
    if (!clk_390_rst_n) begin
      stat_pkts   <= '0;
      stat_beats  <= '0;
      stat_stalls <= '0;
    end else if (start_ok) begin
      stat_pkts   <= '0;
      stat_beats  <= '0;
      stat_stalls <= '0;
    end else begin
      if (hs) begin
        stat_beats <= sat_inc(stat_beats);
      end
      if (hs_last) begin
        stat_pkts <= sat_inc(stat_pkts);
      end
      if (m_axis_tvalid && !m_axis_tready) begin
        stat_stalls <= sat_inc(stat_stalls);
      end
    end
  end
`else
  assign stat_pkts   = '0;
  assign stat_beats  = '0;
  assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Testbench for axis_pkt_gen. Random beat programs are loaded, a reference model expands each
// run into the expected beat stream and inter-packet gaps, and a negedge monitor compares every
// handshaked beat, gap length, hold stability and done pulse against the queues.
// Honours AXIS_PKT_GEN_STATS_EN for the stat_* checks.
`timescale 1ns/1ps
module tb_axis_pkt_gen;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned KEEP_W = 8;
  localparam int unsigned USER_W = 64;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned AW     = 6;
  localparam int unsigned GAP_W  = 16;
  localparam int unsigned RPT_W  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              cfg_we = 1'b0;
  logic [AW-1:0]     cfg_addr = '0;
  logic [DATA_W-1:0] cfg_tdata = '0;
  logic [KEEP_W-1:0] cfg_tkeep = '0;
  logic              cfg_tlast = 1'b0;
  logic [AW:0]       num_beats = '0;
  logic [GAP_W-1:0]  gap_cycles = '0;
  logic [RPT_W-1:0]  repeat_cnt = '0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [DATA_W-1:0] m_axis_tdata;
  logic [KEEP_W-1:0] m_axis_tkeep;
  logic [USER_W-1:0] m_axis_tuser;
  logic              m_axis_tlast;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b1;
  logic              busy;
  logic              done;
  logic [31:0]       stat_pkts;
  logic [31:0]       stat_beats;
  logic [31:0]       stat_stalls;

  axis_pkt_gen #(
    .DATA_W (DATA_W),
    .USER_W (USER_W),
    .DEPTH  (DEPTH),
    .GAP_W  (GAP_W),
    .RPT_W  (RPT_W)
  ) dut (
    .clk_390       (clk),
    .clk_390_rst_n (rst_n),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_tdata     (cfg_tdata),
    .cfg_tkeep     (cfg_tkeep),
    .cfg_tlast     (cfg_tlast),
    .num_beats     (num_beats),
    .gap_cycles    (gap_cycles),
    .repeat_cnt    (repeat_cnt),
    .start         (start),
    .stop          (stop),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .done          (done),
    .stat_pkts     (stat_pkts),
    .stat_beats    (stat_beats),
    .stat_stalls   (stat_stalls)
  );

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic [USER_W-1:0] user;
  } beat_t;

  beat_t             exp_q[$];
  int                gap_q[$];
  logic [DATA_W-1:0] prog_data [DEPTH];
  logic [KEEP_W-1:0] prog_keep [DEPTH];
  logic              prog_last [DEPTH];

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // ---------------- monitor ----------------
  int    beats_seen = 0;
  int    pkts_seen = 0;
  int    stalls_seen = 0;
  int    done_seen = 0;
  bit    gap_pend = 0;
  int    gap_run = 0;
  bit    hold_chk = 0;
  beat_t held;

  always @(negedge clk) begin
    beat_t cur;
    beat_t e;
    if (!rst_n) begin
      hold_chk = 0;
      gap_pend = 0;
    end else begin
      cur = '{data: m_axis_tdata, keep: m_axis_tkeep, last: m_axis_tlast, user: m_axis_tuser};
      if (gap_pend && m_axis_tvalid) begin
        gap_pend = 0;
        if (gap_q.size() == 0) begin
          n_checks++;
          $display("FAIL gap_unexpected_packet: got gap of %0d, expected no further packet",
                   gap_run);
        end else begin
          chk("gap_length", gap_run, gap_q.pop_front());
        end
      end else if (gap_pend) begin
        gap_run++;
      end
      if (hold_chk) begin
        chk("hold_valid", m_axis_tvalid, 1'b1);
        chk("hold_stable", cur, held);
      end
      if (m_axis_tvalid && !m_axis_tready) begin
        stalls_seen++;
        hold_chk = 1;
        held = cur;
      end else begin
        hold_chk = 0;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL extra_beat: got beat %0h, expected none", cur);
        end else begin
          e = exp_q.pop_front();
          chk("beat", cur, e);
        end
        if (m_axis_tlast) begin
          pkts_seen++;
          gap_pend = 1;
          gap_run = 0;
        end
      end
      if (done) begin
        done_seen++;
        gap_pend = 0;
        chk("done_after_last_beat", exp_q.size(), 0);
      end
    end
  end

  // ---------------- tready driver ----------------
  int rdy_mode = 0;  // 0: always ready, 1: alternating, 2: random
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ~m_axis_tready;
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- reference model ----------------
  task automatic gen_exp(input int nb, input int rpt, input int gap, input int max_pkts,
                         output int nbeats, output int npkts);
    logic [USER_W-1:0] seq;
    beat_t b;
    bit fin;
    seq = '0;
    fin = 0;
    nbeats = 0;
    npkts = 0;
    for (int p = 0; !fin; p++) begin
      for (int i = 0; i < nb && !fin; i++) begin
        b.data = prog_data[i];
        b.keep = prog_keep[i];
        b.last = prog_last[i] || (i == nb - 1);
        b.user = seq;
        exp_q.push_back(b);
        nbeats++;
        if (b.last) begin
          npkts++;
          fin = (rpt != 0 && p == rpt - 1 && i == nb - 1) || (max_pkts != 0 && npkts == max_pkts);
          if (!fin) gap_q.push_back(gap);
          seq++;
        end
      end
    end
  endtask

  // ---------------- stimulus helpers (all start and end at posedge+1) ----------------
  task automatic cfg_wr(input int a, input logic [DATA_W-1:0] d, input logic [KEEP_W-1:0] k,
                        input logic l, input bit shadow);
    cfg_we = 1'b1;
    cfg_addr = AW'(a);
    cfg_tdata = d;
    cfg_tkeep = k;
    cfg_tlast = l;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    if (shadow) begin
      prog_data[a] = d;
      prog_keep[a] = k;
      prog_last[a] = l;
    end
  endtask

  task automatic load_prog(input int nb, input logic [7:0] last_mask);
    for (int i = 0; i < nb; i++) begin
      cfg_wr(i, {$urandom, $urandom}, KEEP_W'($urandom), last_mask[i], 1'b1);
    end
  endtask

  task automatic do_start(input int nb, input int gap, input int rpt, input bit stp);
    num_beats = (AW+1)'(nb);
    gap_cycles = GAP_W'(gap);
    repeat_cnt = RPT_W'(rpt);
    start = 1'b1;
    stop = stp;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop = 1'b0;
  endtask

  task automatic wait_done(input string name, input int d0);
    int n;
    n = 0;
    while (done_seen == d0 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_done_once"}, done_seen - d0, 1);
    chk({name, "_exp_drained"}, exp_q.size(), 0);
    chk({name, "_gaps_drained"}, gap_q.size(), 0);
    chk({name, "_busy_low"}, busy, 1'b0);
  endtask

  task automatic run(input string name, input int nb, input int gap, input int rpt);
    int nbeats, npkts, d0;
    d0 = done_seen;
    stalls_seen = 0;
    gen_exp(nb, rpt, gap, 0, nbeats, npkts);
    do_start(nb, gap, rpt, 1'b0);
    wait_done(name, d0);
`ifdef AXIS_PKT_GEN_STATS_EN
    chk({name, "_stat_beats"}, stat_beats, nbeats);
    chk({name, "_stat_pkts"}, stat_pkts, npkts);
    chk({name, "_stat_stalls"}, stat_stalls, stalls_seen);
`else
    chk({name, "_stat_tied"}, {stat_beats, stat_pkts, stat_stalls}, 96'd0);
`endif
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int nbeats, npkts, d0, b0, p0, n;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tvalid", m_axis_tvalid, 1'b0);
    chk("reset_outputs", {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast}, '0);
    chk("reset_busy_done", {busy, done}, 2'b00);
    chk("reset_stats", {stat_beats, stat_pkts, stat_stalls}, 96'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 3-beat packet, two passes, full rate then alternating tready
    load_prog(3, 8'b100);
    rdy_mode = 0;
    run("contiguous", 3, 0, 2);
    rdy_mode = 1;
    run("alt_ready", 3, 0, 2);

    // two 2-beat packets with gaps
    load_prog(4, 8'b1010);
    rdy_mode = 0;
    run("gap4", 4, 4, 1);
    rdy_mode = 2;
    run("gap_rand", 4, int'($urandom_range(1, 7)), 2);

    // endless run stopped during packet 3
    load_prog(3, 8'b100);
    rdy_mode = 0;
    d0 = done_seen;
    p0 = pkts_seen;
    b0 = beats_seen;
    gen_exp(3, 0, 0, 3, nbeats, npkts);
    do_start(3, 0, 0, 1'b0);
    n = 0;
    while (beats_seen < b0 + 7 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    wait_done("stop_mid", d0);
    chk("stop_mid_pkts", pkts_seen - p0, 3);

    // no tlast in the program: last index forced
    load_prog(5, 8'b0);
    rdy_mode = 2;
    run("forced_last", 5, 0, 1);

    // illegal lengths are ignored
    rdy_mode = 0;
    d0 = done_seen;
    do_start(0, 0, 1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("nb0_busy", busy, 1'b0);
    do_start(DEPTH + 1, 0, 1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("nb_over_busy", {busy, m_axis_tvalid}, 2'b00);
    chk("illegal_no_done", done_seen, d0);

    // writes while busy are dropped; write + start in one cycle uses new data
    load_prog(3, 8'b100);
    d0 = done_seen;
    gen_exp(3, 2, 0, 0, nbeats, npkts);
    do_start(3, 0, 2, 1'b0);
    cfg_wr(1, {$urandom, $urandom}, KEEP_W'($urandom), 1'b1, 1'b0);
    wait_done("busy_write", d0);
    d0 = done_seen;
    prog_data[0] = {$urandom, $urandom};
    prog_keep[0] = KEEP_W'($urandom);
    prog_last[0] = 1'b0;
    gen_exp(3, 1, 0, 0, nbeats, npkts);
    cfg_we = 1'b1;
    cfg_addr = '0;
    cfg_tdata = prog_data[0];
    cfg_tkeep = prog_keep[0];
    cfg_tlast = 1'b0;
    do_start(3, 0, 1, 1'b0);
    cfg_we = 1'b0;
    wait_done("write_and_start", d0);

    // start and stop together: exactly one packet
    load_prog(4, 8'b0010);
    d0 = done_seen;
    p0 = pkts_seen;
    gen_exp(4, 0, 0, 1, nbeats, npkts);
    do_start(4, 0, 0, 1'b1);
    wait_done("start_stop", d0);
    chk("start_stop_pkts", pkts_seen - p0, 1);

    // reset mid-packet, then restart from index 0 with tuser 0
    load_prog(3, 8'b100);
    gen_exp(3, 0, 0, 2, nbeats, npkts);
    b0 = beats_seen;
    do_start(3, 0, 0, 1'b0);
    n = 0;
    while (beats_seen < b0 + 4 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_tvalid", m_axis_tvalid, 1'b0);
    chk("async_reset_busy", busy, 1'b0);
    exp_q.delete();
    gap_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run("after_reset", 3, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // hard ceiling so the run always terminates
  initial begin
    #2000000;
    $display("FAIL global_timeout: got no end of test, expected completion");
    $fatal(1, "timeout");
  end

endmodule
